// File: rtl/nibbler_mem_pkg.sv
// Shared types for the NibblER memory path: bus widths, address/nibble types
// and the RAM access sequencer state encoding.
package nibbler_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } mem_state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// Single-request sequencer driving the nibble RAM pins through a fixed
// setup / strobe / recover cycle; sole owner of csRAM, weRAM and the data bus.
module ram_access_ctrl #(
  parameter int ADDR_W      = nibbler_mem_pkg::ADDR_W,
  parameter int DATA_W      = nibbler_mem_pkg::DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              csRAM,
  output logic              weRAM,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data
);
  import nibbler_mem_pkg::*;

  localparam int CNT_W = 4;

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_last;
  logic              w_drive;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_last   = (r_state == STROBE) && (r_cnt == '0);
  // Bus enable comes only from registered state, so reset drops it at once.
  assign w_drive  = (r_state == STROBE) && r_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = SETUP;
      SETUP:   w_next = STROBE;
      STROBE:  if (r_cnt == '0) w_next = RECOVER;
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == SETUP)
        r_cnt <= CNT_W'(WAIT_CYCLES);
      else if ((r_state == STROBE) && (r_cnt != '0))
        r_cnt <= r_cnt - 1'b1;
      // Sample at the end of the last strobe cycle to give the RAM the full window.
      if (w_last && !r_we)
        r_rdata <= data;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RECOVER);
  assign rsp_rdata = r_rdata;
  assign csRAM     = (r_state == SETUP) || (r_state == STROBE);
  assign weRAM     = w_drive;
  assign address   = r_addr;
  assign data      = w_drive ? r_wdata : {DATA_W{1'bz}};

endmodule
